// File: rtl/iotdf_pkg.sv
// Shared constants and FSM encoding for the IOT data-filter result serialiser.
package iotdf_pkg;

    localparam int unsigned FN_W          = 3;
    localparam int unsigned FRAME_BYTES   = 17;
    localparam logic [4:0]  FRAME_HDR_TAG = 5'b10100;

    typedef enum logic [2:0] {
        FN_NONE = 3'd0,
        FN_MAX  = 3'd1,
        FN_MIN  = 3'd2,
        FN_AVG  = 3'd3,
        FN_EXT  = 3'd4,
        FN_EXC  = 3'd5,
        FN_PMAX = 3'd6,
        FN_PMIN = 3'd7
    } fn_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2
    } ser_state_e;

endpackage

// File: rtl/iotdf_res_fifo.sv
// Synchronous result FIFO with separate pointers and level; exposes the current
// head and the head as it will look after this cycle's push/pop.
module iotdf_res_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 131
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic                   full_c,
    output logic                   empty_c,
    output logic [$clog2(DEPTH):0] level,
    output logic [W-1:0]           head_c,
    output logic [W-1:0]           head_nxt_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full_c  = (level == LVL_W'(DEPTH));
    assign empty_c = (level == '0);
    assign do_pop  = pop && !empty_c;
    assign do_push = push && (!full_c || do_pop);
    assign head_c  = mem[rd_ptr];

    // A push into an entry that is simultaneously emptied becomes the new head.
    always_comb begin
        head_nxt_c = mem[rd_ptr];
        if (do_pop) begin
            head_nxt_c = (level == LVL_W'(1)) ? wdata : mem[PTR_W'(rd_ptr + 1'b1)];
        end else if (empty_c) begin
            head_nxt_c = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
            if (do_pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/iotdf_res_ser.sv
// Buffers 128-bit filter results and serialises each as a 17-byte ready/valid
// frame (header {tag, fn} followed by payload MSB byte first).
module iotdf_res_ser
    import iotdf_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned DW      = (FRAME_BYTES - 1) * 8,
    parameter logic [4:0]  HDR_TAG = FRAME_HDR_TAG
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   res_valid,
    input  logic [DW-1:0]          res_data,
    input  logic [FN_W-1:0]        res_fn,
    output logic                   out_valid,
    output logic [7:0]             out_byte,
    output logic                   out_sop,
    output logic                   out_eop,
    input  logic                   out_ready,
    output logic                   ovf,
    output logic [7:0]             drop_cnt,
    output logic [$clog2(DEPTH):0] fifo_lvl
);

    localparam int unsigned ENT_W  = FN_W + DW;
    localparam int unsigned NBYTES = DW / 8;
    localparam int unsigned IDX_W  = $clog2(NBYTES);
    localparam int unsigned POS_W  = $clog2(NBYTES + 1);
    localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    ser_state_e       state;
    logic [IDX_W-1:0] byte_idx;
    logic [ENT_W-1:0] head_c;
    logic [ENT_W-1:0] head_nxt_c;
    logic             full_c;
    logic             empty_c;
    logic             pop_now_c;
    logic             push_c;
    logic             drop_c;
    logic             more_c;

    // Frame position 0 is the header; positions 1..NBYTES walk the payload MSB first.
    function automatic logic [7:0] frame_byte(input logic [ENT_W-1:0] e, input logic [POS_W-1:0] pos);
        if (pos == '0) return {HDR_TAG, e[ENT_W-1 -: FN_W]};
        return 8'(e[DW-1:0] >> (8 * (NBYTES - int'(pos))));
    endfunction

    assign pop_now_c = (state == S_DATA) && (byte_idx == LAST_IDX) && out_valid && out_ready;
    assign push_c    = res_valid && (!full_c || pop_now_c);
    assign drop_c    = res_valid && full_c && !pop_now_c;
    assign more_c    = (fifo_lvl > LVL_W'(1)) || res_valid;

    iotdf_res_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_c),
        .pop        (pop_now_c),
        .wdata      ({res_fn, res_data}),
        .full_c     (full_c),
        .empty_c    (empty_c),
        .level      (fifo_lvl),
        .head_c     (head_c),
        .head_nxt_c (head_nxt_c)
    );

    // Frame FSM; output registers are loaded with the byte for the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            byte_idx  <= '0;
            out_valid <= 1'b0;
            out_byte  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty_c) begin
                        state     <= S_HDR;
                        out_valid <= 1'b1;
                        out_sop   <= 1'b1;
                        out_byte  <= frame_byte(head_c, POS_W'(0));
                    end
                end
                S_HDR: begin
                    if (out_ready) begin
                        state    <= S_DATA;
                        byte_idx <= '0;
                        out_sop  <= 1'b0;
                        out_eop  <= 1'b0;
                        out_byte <= frame_byte(head_c, POS_W'(1));
                    end
                end
                S_DATA: begin
                    if (out_ready) begin
                        if (byte_idx == LAST_IDX) begin
                            out_eop <= 1'b0;
                            if (more_c) begin
                                state    <= S_HDR;
                                out_sop  <= 1'b1;
                                out_byte <= frame_byte(head_nxt_c, POS_W'(0));
                            end else begin
                                state     <= S_IDLE;
                                out_valid <= 1'b0;
                                out_byte  <= '0;
                            end
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            out_eop  <= (byte_idx + 1'b1 == LAST_IDX);
                            out_byte <= frame_byte(head_c, POS_W'(byte_idx) + POS_W'(2));
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop_c) begin
            ovf <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_iotdf_res_ser.sv
// Self-checking bench for iotdf_res_ser: directed scenarios plus random traffic
// checked every cycle against a queue-based frame model.
module tb_iotdf_res_ser;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [2:0]   fn;
        logic [127:0] d;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         res_valid = 1'b0;
    logic [127:0] res_data = '0;
    logic [2:0]   res_fn = '0;
    logic         out_ready = 1'b0;
    logic         out_valid;
    logic [7:0]   out_byte;
    logic         out_sop;
    logic         out_eop;
    logic         ovf;
    logic [7:0]   drop_cnt;
    logic [2:0]   fifo_lvl;

    int   total = 0;
    int   bad = 0;
    ent_t q[$];
    bit   busy = 0;
    int   pos = 0;
    bit   m_ovf = 0;
    int   m_drop = 0;
    int   hs_cnt = 0;

    iotdf_res_ser #(.DEPTH(DEPTH), .DW(128), .HDR_TAG(5'b10100)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_fn    (res_fn),
        .out_valid (out_valid),
        .out_byte  (out_byte),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_ready (out_ready),
        .ovf       (ovf),
        .drop_cnt  (drop_cnt),
        .fifo_lvl  (fifo_lvl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input ent_t e, input int p);
        logic [127:0] d;
        d = e.d;
        if (p == 0) return {5'b10100, e.fn};
        return d[127 - 8*(p-1) -: 8];
    endfunction

    // Model: queue of stored results, plus the frame position shown on the link.
    function automatic void model_edge(input bit rv, input ent_t e, input bit rdy);
        int sz0;
        bit hs;
        bit popnow;
        bit acc;
        sz0    = q.size();
        hs     = busy && rdy;
        popnow = hs && (pos == 16);
        acc    = rv && ((sz0 < DEPTH) || popnow);
        if (rv && !acc) begin
            m_ovf = 1;
            if (m_drop < 255) m_drop++;
        end
        if (popnow) void'(q.pop_front());
        if (acc) q.push_back(e);
        if (!busy) begin
            busy = (sz0 != 0);
            pos  = 0;
        end else if (hs) begin
            if (pos == 16) begin
                pos  = 0;
                busy = (q.size() != 0);
            end else begin
                pos++;
            end
        end
    endfunction

    task automatic check_outputs();
        chk("out_valid", 128'(out_valid), 128'(busy));
        chk("fifo_lvl", 128'(fifo_lvl), 128'(q.size()));
        chk("ovf", 128'(ovf), 128'(m_ovf));
        chk("drop_cnt", 128'(drop_cnt), 128'(m_drop));
        if (busy) begin
            chk("out_byte", 128'(out_byte), 128'(exp_byte(q[0], pos)));
            chk("out_sop", 128'(out_sop), 128'(pos == 0));
            chk("out_eop", 128'(out_eop), 128'(pos == 16));
        end else begin
            chk("idle_sop", 128'(out_sop), 128'(0));
            chk("idle_eop", 128'(out_eop), 128'(0));
        end
    endtask

    task automatic cyc(input bit rv, input logic [2:0] fn, input logic [127:0] d, input bit rdy);
        ent_t e;
        e.fn = fn;
        e.d  = d;
        res_valid = rv;
        res_fn    = fn;
        res_data  = d;
        out_ready = rdy;
        if (out_valid && rdy) hs_cnt++;
        model_edge(rv, e, rdy);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input bit rdy);
        cyc(1'b0, 3'd0, 128'd0, rdy);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        res_valid = 1'b0;
        q.delete();
        busy = 0;
        pos = 0;
        m_ovf = 0;
        m_drop = 0;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_sop", 128'(out_sop), 128'(0));
        chk("rst_out_eop", 128'(out_eop), 128'(0));
        chk("rst_out_byte", 128'(out_byte), 128'(0));
        chk("rst_ovf", 128'(ovf), 128'(0));
        chk("rst_drop_cnt", 128'(drop_cnt), 128'(0));
        chk("rst_fifo_lvl", 128'(fifo_lvl), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int vcnt;
        int run;
        int maxrun;
        int sops;
        bit fired;
        bit pat[4];

        #2;
        do_reset();

        // Single result, ready held high: header at t+2, then payload MSB first.
        cyc(1'b1, 3'd3, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1);
        chk("single_t1_valid", 128'(out_valid), 128'(0));
        idle(1'b1);
        chk("single_hdr_byte", 128'(out_byte), 128'(8'hA3));
        chk("single_hdr_sop", 128'(out_sop), 128'(1));
        for (int i = 0; i < 17; i++) idle(1'b1);
        chk("single_lvl_end", 128'(fifo_lvl), 128'(0));
        chk("single_valid_end", 128'(out_valid), 128'(0));

        // Backpressure with ready pattern 1,0,0,1: frame content unchanged, 17 handshakes.
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        hs_cnt = 0;
        cyc(1'b1, 3'd3, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1);
        for (int i = 0; i < 80; i++) idle(pat[i % 4]);
        chk("bp_handshakes", 128'(hs_cnt), 128'(17));

        // Overflow: five results with the link stalled, then saturate the drop counter.
        for (int i = 0; i < 5; i++) cyc(1'b1, 3'(i), rnd128(), 1'b0);
        chk("ovf_lvl", 128'(fifo_lvl), 128'(4));
        chk("ovf_flag", 128'(ovf), 128'(1));
        chk("ovf_drop1", 128'(drop_cnt), 128'(1));
        for (int i = 0; i < 300; i++) cyc(1'b1, 3'd6, rnd128(), 1'b0);
        chk("ovf_drop_sat", 128'(drop_cnt), 128'(255));
        for (int i = 0; i < 90; i++) idle(1'b1);

        // Push coincident with the eop handshake while full is accepted.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 3'(i + 1), rnd128(), 1'b0);
        fired = 0;
        for (int i = 0; i < 200 && !fired; i++) begin
            if (busy && pos == 16) begin
                cyc(1'b1, 3'd7, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 1'b1);
                fired = 1;
                chk("fullpop_lvl", 128'(fifo_lvl), 128'(4));
                chk("fullpop_ovf", 128'(ovf), 128'(0));
            end else begin
                idle(1'b1);
            end
        end
        chk("fullpop_fired", 128'(fired), 128'(1));
        for (int i = 0; i < 80; i++) idle(1'b1);
        chk("fullpop_drained", 128'(fifo_lvl), 128'(0));

        // Back-to-back frames: 34 contiguous valid bytes, two headers.
        vcnt = 0; run = 0; maxrun = 0; sops = 0;
        for (int i = 0; i < 60; i++) begin
            if (i == 0)      cyc(1'b1, 3'd4, rnd128(), 1'b1);
            else if (i == 8) cyc(1'b1, 3'd5, rnd128(), 1'b1);
            else             idle(1'b1);
            if (out_valid) begin
                vcnt++; run++;
                if (out_sop) sops++;
            end else begin
                run = 0;
            end
            if (run > maxrun) maxrun = run;
        end
        chk("b2b_valid_cnt", 128'(vcnt), 128'(34));
        chk("b2b_max_run", 128'(maxrun), 128'(34));
        chk("b2b_sops", 128'(sops), 128'(2));

        // Reset in the middle of a frame discards it.
        cyc(1'b1, 3'd2, rnd128(), 1'b1);
        for (int i = 0; i < 30 && !(busy && pos == 6); i++) idle(1'b1);
        chk("midrst_reached", 128'(busy && pos == 6), 128'(1));
        do_reset();
        for (int i = 0; i < 20; i++) idle(1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)), rnd128(),
                ($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 120; i++) idle(1'b1);
        chk("final_lvl", 128'(fifo_lvl), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
